// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the multi-channel memory arbiter/controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Channel-id width. It is never narrower than one bit, so a single-channel
    // build still has a legal id vector.
    function automatic int calc_ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arb_ctrl_rr_arbiter.sv
// Round-robin grant: the first requester at or after ptr, wrapping modulo N.
// Latency: purely combinational, no state. The parent owns the pointer.
// Backpressure: when en is low, no grant is issued.
// Ports: req   - per-requester request
//        ptr   - priority start index (< N)
//        en    - grant enable
//        gnt   - one-hot grant, or zero
//        gnt_id - encoded index of the granted requester (0 when there is no grant)
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int W = calc_ch_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id
);

    always_comb begin
        logic found;
        int   idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            // Walk from ptr upward and wrap. ptr is always < N, so one
            // subtraction is enough.
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// CH requesters share one single-port RAM through a round-robin grant. After each reset, a sweep zeroes the whole array.
// Latency: read data is registered, with rsp_valid one cycle after the accept edge. Writes complete at the accept edge.
// Backpressure: no command is granted while a response waits with rsp_ready low. A pop and a new read may share a cycle.
// Ports: clk/rst (async, active-high); cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata per channel (packed, channel i at
//        i*W); rsp_valid/rsp_ready/rsp_data/rsp_ch response; init_done after the sweep; last_addr of the latest accept.
module mem_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int CH     = 2,
    parameter int CH_W   = calc_ch_w(CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        cmd_valid,
    output logic [CH-1:0]        cmd_ready,
    input  logic [CH-1:0]        cmd_we,
    input  logic [CH*ADDR_W-1:0] cmd_addr,
    input  logic [CH*DATA_W-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic [CH_W-1:0]      rsp_ch,
    output logic                 init_done,
    output logic [ADDR_W-1:0]    last_addr
);

    // ---------------- state ----------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic [CH_W-1:0]     r_rr_ptr;
    logic                r_rsp_vld;
    logic [DATA_W-1:0]   r_rsp_dat;
    logic [CH_W-1:0]     r_rsp_ch;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    // ---------------- comb ----------------
    logic                w_init_active;
    logic                w_init_done;
    logic                w_slot_free;
    logic                w_arb_en;
    logic [CH-1:0]       w_gnt;
    logic [CH_W-1:0]     w_gnt_id;
    logic                w_xfer;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_in_range;
    logic                w_rd_xfer;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdat;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_init_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_init_active = 1'b0;
        w_init_done   = 1'b0;
        case (r_state)
            ST_INIT: w_init_active = 1'b1;
            ST_RUN:  w_init_done   = 1'b1;
            default: w_init_active = 1'b1;
        endcase
    end

    // Sweep address. It holds after the sweep; it only matters in INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_cnt <= '0;
        end else if (w_init_active && (r_init_cnt != ADDR_W'(DEPTH - 1))) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    // A new command may enter only when the response register is empty or is being drained this cycle.
    assign w_slot_free = !r_rsp_vld || rsp_ready;
    assign w_arb_en    = w_init_done && w_slot_free;

    rr_arbiter #(
        .N (CH),
        .W (CH_W)
    ) u_arb (
        .req    (cmd_valid),
        .ptr    (r_rr_ptr),
        .en     (w_arb_en),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign cmd_ready = w_gnt;
    // A grant is issued only to a valid channel, so any grant is a transfer.
    assign w_xfer    = |w_gnt;

    assign w_sel_we    = cmd_we[w_gnt_id];
    assign w_sel_addr  = cmd_addr[w_gnt_id * ADDR_W +: ADDR_W];
    assign w_sel_wdata = cmd_wdata[w_gnt_id * DATA_W +: DATA_W];
    assign w_in_range  = int'(w_sel_addr) < DEPTH;
    assign w_rd_xfer   = w_xfer && !w_sel_we;

    // Single write port. The clear sweep owns it during INIT, and no command can be granted then.
    assign w_mem_we   = w_init_active || (w_xfer && w_sel_we && w_in_range);
    assign w_mem_addr = w_init_active ? r_init_cnt : w_sel_addr;
    assign w_mem_wdat = w_init_active ? '0 : w_sel_wdata;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdat;
        end
    end

    // Response register, arbitration pointer and last-address tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_vld   <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_ch    <= '0;
            r_last_addr <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_last_addr <= w_sel_addr;
                r_rr_ptr    <= (int'(w_gnt_id) == CH - 1) ? '0 : w_gnt_id + 1'b1;
            end
            if (w_rd_xfer) begin
                r_rsp_vld <= 1'b1;
                r_rsp_dat <= w_in_range ? r_mem[w_sel_addr] : '0;
                r_rsp_ch  <= w_gnt_id;
            end else if (rsp_ready) begin
                r_rsp_vld <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_vld;
    assign rsp_data  = r_rsp_dat;
    assign rsp_ch    = r_rsp_ch;
    assign init_done = w_init_done;
    assign last_addr = r_last_addr;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl. The main instance has DEPTH=200, so addresses 200..255 are out of range.
// A small DEPTH=16 instance times the clear sweep.
// Responses are checked against a queue of expected values that is filled when each read is issued.
module tb_mem_arb_ctrl;

    localparam int DW = 19;
    localparam int AW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [0:0]    ch;
    } rsp_t;

    logic            clk, rst;
    logic [1:0]      cmd_valid, cmd_ready, cmd_we;
    logic [2*AW-1:0] cmd_addr;
    logic [2*DW-1:0] cmd_wdata;
    logic            rsp_valid, rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [0:0]      rsp_ch;
    logic            init_done;
    logic [AW-1:0]   last_addr;

    logic [1:0]      v16, rdy16;
    logic [7:0]      a16;
    logic            rr16, rv16, id16;
    logic [DW-1:0]   rd16;
    logic [0:0]      rc16;
    logic [3:0]      la16;

    int   total = 0;
    int   bad   = 0;
    rsp_t exp_q[$];

    mem_arb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .CH(2)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ch(rsp_ch), .init_done(init_done), .last_addr(last_addr)
    );

    mem_arb_ctrl #(.DATA_W(DW), .ADDR_W(4), .DEPTH(16), .CH(2)) u_dut16 (
        .clk(clk), .rst(rst), .cmd_valid(v16), .cmd_ready(rdy16), .cmd_we(2'b00),
        .cmd_addr(a16), .cmd_wdata(cmd_wdata), .rsp_valid(rv16), .rsp_ready(rr16),
        .rsp_data(rd16), .rsp_ch(rc16), .init_done(id16), .last_addr(la16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_cmd(input int ch, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        cmd_valid[ch]           = 1'b1;
        cmd_we[ch]              = we;
        cmd_addr[ch*AW +: AW]   = addr;
        cmd_wdata[ch*DW +: DW]  = wd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response handshake pops and checks one expected entry.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got rsp %0h ch %0d expected none", rsp_data, rsp_ch);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_ch", 32'(rsp_ch), 32'(e.ch));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; cmd_valid = '0; cmd_we = '0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; v16 = '0; a16 = {4'd5, 4'd5}; rr16 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_cmd(0, 1'b0, 8'd5, '0);
        set_cmd(1, 1'b0, 8'd5, '0);
        v16 = 2'b01;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_ch", 32'(rsp_ch), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_last_addr", 32'(last_addr), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        rst = 1'b0;

        // Clear sweep: DEPTH=16 instance and DEPTH=200 instance, both with requests held
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= 16) begin
                chk("init16_done", 32'(id16), (k == 16) ? 1 : 0);
                chk("init16_ready", 32'(rdy16), (k == 16) ? 1 : 0);
            end
            if (k == 17) begin
                chk("init16_rd_vld", 32'(rv16), 1);
                chk("init16_rd_data", 32'(rd16), 0);
                chk("init16_rd_ch", 32'(rc16), 0);
                v16 = 2'b00;
            end
            if (k == 18) chk("init16_rd_clr", 32'(rv16), 0);
            chk("init_done", 32'(init_done), (k == 200) ? 1 : 0);
            chk("init_ready", 32'(cmd_ready), (k == 200) ? 1 : 0);
            if (k == 200) exp_q.push_back({19'd0, 1'b0});  // ch0 reads addr 5 after sweep
        end
        cyc();
        cmd_valid = '0;

        // Write then read-back on the other channel, back to back
        set_cmd(0, 1'b1, 8'h22, 19'h1ABCD);
        cyc();
        cmd_valid = '0;
        set_cmd(1, 1'b0, 8'h22, '0);
        exp_q.push_back({19'h1ABCD, 1'b1});
        cyc();
        cmd_valid = '0;
        @(negedge clk);
        chk("wr_rd_last_addr", 32'(last_addr), 32'h22);
        chk("wr_rd_latency", 32'(rsp_valid), 1);
        cyc();

        // Preload 0x10..0x15 with alternating channels, so that ch1 is granted last
        for (int i = 0; i < 6; i++) begin
            cmd_valid = '0;
            set_cmd(i % 2, 1'b1, AW'(8'h10 + i), DW'(19'h100 + i));
            cyc();
        end
        cmd_valid = '0;

        // Fairness: both channels read continuously; grants alternate starting with ch0
        set_cmd(0, 1'b0, 8'h10, '0);
        set_cmd(1, 1'b0, 8'h11, '0);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_q.push_back({19'h100, 1'b0});
            else            exp_q.push_back({19'h101, 1'b1});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(cmd_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            cyc();
        end
        cmd_valid = '0;
        cyc();

        // Backpressure: a response stalls; then release with pop and a new load in the same cycle
        rsp_ready = 1'b0;
        set_cmd(0, 1'b0, 8'h12, '0);
        exp_q.push_back({19'h102, 1'b0});
        cyc();
        cmd_valid = '0;
        set_cmd(1, 1'b0, 8'h13, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", 32'(cmd_ready), 0);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_data", 32'(rsp_data), 32'h102);
            cyc();
        end
        rsp_ready = 1'b1;
        exp_q.push_back({19'h103, 1'b1});
        @(negedge clk);
        chk("bp_release_ready", 32'(cmd_ready), 32'h2);
        cyc();
        cmd_valid = '0;
        @(negedge clk);
        chk("bp_no_bubble", 32'(rsp_valid), 1);
        cyc();
        cyc();

        // Out-of-range: a write to 250 is dropped and a read of 250 gives 0; the last in-range word, 199, works
        set_cmd(1, 1'b1, 8'd250, 19'h7);
        cyc();
        cmd_valid = '0;
        set_cmd(1, 1'b1, 8'd199, 19'h5A5A);
        cyc();
        cmd_valid = '0;
        set_cmd(0, 1'b0, 8'd250, '0);
        exp_q.push_back({19'h0, 1'b0});
        cyc();
        cmd_valid = '0;
        @(negedge clk);
        chk("oor_last_addr", 32'(last_addr), 250);
        cyc();
        set_cmd(0, 1'b0, 8'd199, '0);
        exp_q.push_back({19'h5A5A, 1'b0});
        cyc();
        cmd_valid = '0;
        cyc();

        // Reset while a response is pending
        rsp_ready = 1'b0;
        set_cmd(0, 1'b0, 8'h22, '0);
        cyc();
        cmd_valid = '0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(rsp_valid), 1);
        set_cmd(0, 1'b0, 8'h22, '0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_data", 32'(rsp_data), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        chk("mid_rst_done", 32'(init_done), 0);
        chk("mid_rst_last_addr", 32'(last_addr), 0);
        cmd_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (!init_done && n < 300) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("reinit_len", 32'(n), 200);
        cyc();
        set_cmd(0, 1'b0, 8'h22, '0);
        exp_q.push_back({19'h0, 1'b0});
        cyc();
        cmd_valid = '0;
        set_cmd(1, 1'b0, 8'h10, '0);
        exp_q.push_back({19'h0, 1'b1});
        cyc();
        cmd_valid = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
# mem_arb_ctrl

Parametrised multi-channel memory controller: `CH` requesters share one synchronous single-port RAM (`DEPTH` × `DATA_W`) through a round-robin arbiter.
- Commands use valid/ready handshakes; read data returns on a registered response channel with backpressure.
- After every reset, a hardware sweep clears the whole array to zero before any command is accepted.
- Sits between instruction/data producers and storage, replacing the single-channel, unhandshaked memory interface.

## Interface
- `DATA_W`, 19: word width.
- `ADDR_W`, 8: address width.
- `DEPTH`, 2**ADDR_W: number of words, must be ≤ 2**ADDR_W.
- `CH`, 2: number of requester channels, ≥ 1.
- `CH_W`, max(1, clog2(CH)): channel-id width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  CH  per-channel command valid.
- `cmd_ready`  out  CH  per-channel accept (one-hot or zero).
- `cmd_we`  in  CH  1 = write, 0 = read.
- `cmd_addr`  in  CH*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W].
- `cmd_wdata`  in  CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
- `rsp_valid`  out  1  read data valid.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  DATA_W  read data.
- `rsp_ch`  out  CH_W  channel that issued the read.
- `init_done`  out  1  high once the clear sweep is complete.
- `last_addr`  out  ADDR_W  address of the most recently accepted command.

## Operation
- FSM states:
  - INIT (reset state): counter `init_cnt` 0..DEPTH-1 writes zero to `mem[init_cnt]` each cycle. When `init_cnt == DEPTH-1`, go to RUN.
  - RUN: stays in RUN until reset.
- In INIT, `cmd_ready` is 0 and `init_done` is 0. In RUN, `init_done` is 1.
- Acceptance condition: `slot_free = !rsp_valid || rsp_ready`. In RUN with `slot_free`, the arbiter grants one valid channel; `cmd_ready` is high for that channel only. A transfer occurs on `cmd_valid[i] && cmd_ready[i]`.
- Round-robin arbitration: pointer `rr_ptr`. The granted channel is the first valid channel at or after `rr_ptr`, modulo CH. After a transfer, `rr_ptr` becomes granted+1 (mod CH). With no transfer, `rr_ptr` holds.
- Write transfer: `mem[addr] <= wdata`. No response is generated.
- Read transfer: `rsp_data <= mem[addr]`, `rsp_ch <=` granted id, `rsp_valid <= 1`, all at the next edge.
- Every transfer: `last_addr <= addr`.
- Response: holds `rsp_data`/`rsp_ch` stable while `rsp_valid && !rsp_ready`. It clears when popped with no new read accepted in the same cycle. Pop plus new read in the same cycle loads the new data (back-to-back, no bubble).
- Addresses ≥ DEPTH: writes are dropped, reads return 0. `last_addr` still updates.
- Reset outputs: `cmd_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_ch` = 0, `init_done` = 0, `last_addr` = 0, `rr_ptr` = 0, state = INIT, `init_cnt` = 0.

## Timing
- INIT lasts exactly DEPTH cycles after reset deassertion. The first command is accepted at cycle DEPTH.
- Read latency: 1 cycle from the accept edge to `rsp_valid`.
- Throughput: one command per cycle while `rsp_ready` = 1.
- Read of an address written in the previous cycle returns the new data. Same-cycle read and write cannot occur (single grant).
- `cmd_ready` is combinational from `cmd_valid`, FSM state, `rsp_valid` and `rsp_ready`. It does not depend on `cmd_we`/`cmd_addr`/`cmd_wdata`.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately.
  - A pending response is discarded.
  - INIT restarts from address 0; array contents become undefined until the sweep rewrites them.

## Structure
- Package `mem_arb_pkg` holds:
  - FSM state enum `{ST_INIT, ST_RUN}`.
  - Helper function computing CH_W.
- Sub-module `rr_arbiter #(N)`: inputs `req[N]`, `ptr`, `en`; output one-hot `gnt` plus encoded id. Purely combinational; `rr_ptr` lives in the parent.
- RAM is an inferred array in the parent, one write port, one registered read. The INIT write is muxed onto the same write port.

## Test plan
- Init sweep: DEPTH=16. Check `init_done` rises exactly 16 cycles after reset release and `cmd_ready` stays 0 throughout. Then read addr 5 -> `rsp_data` = 0.
- Write/read: ch0 writes 0x1ABCD to addr 0x22. Next cycle ch1 reads 0x22 -> after 1 cycle `rsp_valid` = 1, `rsp_data` = 0x1ABCD, `rsp_ch` = 1, `last_addr` = 0x22.
- Fairness: both channels hold valid reads for 6 cycles -> grants alternate 0,1,0,1,0,1 and each response carries the matching `rsp_ch`.
- Backpressure: hold `rsp_ready` = 0 with a response pending -> `cmd_ready` = 0 and `rsp_data` stable. Release -> pop and next read land in the same cycle with no bubble.
- Out-of-range: DEPTH=200, ADDR_W=8. Write 0x7 to addr 250, then read 250 -> `rsp_data` = 0.
- Reset mid-stream: assert `rst` while `rsp_valid` = 1 -> `rsp_valid` = 0 immediately. After release, INIT repeats and earlier data reads back 0.
